unsat_clause_buffer: RTL and testbench

Multi-port collection buffer for the WalkSAT datapath: during clause evaluation up to WRITE_PORTS clause evaluators push the indices of unsatisfied clauses each cycle, and during the flip phase the controller requests a uniformly-indexed random unsatisfied clause. This generalises the single-entry unsat-clause store to a parametrised depth and write-channel count, with in-cycle lane compaction, a fully pipelined random pick and a single-cycle clear between tries. It sits between the clause evaluators and the variable-selection logic inside the datapath.

---
 rtl/unsat_clause_buffer.sv | 236 +++++++++++++++++++++++
 tb/tb_unsat_clause_buffer.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unsat_clause_buffer.sv
// -----------------------------------------------------------------------------
// unsat_clause_buffer
//
// Collection buffer for unsatisfied clause indices in the WalkSAT datapath.
// During clause evaluation up to WRITE_PORTS evaluators push clause indices
// in the same cycle; the valid lanes are compacted in lane order into the next
// free slots. During the flip phase the controller requests a random entry;
// the pick is a two-stage pipeline (index computation, then storage read)
// that accepts a new request every cycle. A single-cycle clear empties the
// buffer between tries without touching the stored contents.
//
// Ports
//   clk            clock, all state updates on the rising edge
//   reset          asynchronous active-high reset
//   clear_i        empties the buffer (count <- 0, overflow <- 0)
//   wr_valid_i     per-lane push request
//   wr_clause_i    lane k clause index at bits [k*CAW +: CAW]
//   wr_ready_o     free slots >= WRITE_PORTS (combinational)
//   pick_req_i     random-pick request
//   rand_i         random value sampled together with pick_req_i
//   pick_valid_o   one-cycle result strobe, two cycles after the request
//   pick_clause_o  picked clause index (holds when pick_valid_o = 0)
//   pick_empty_o   qualifies pick_valid_o: buffer was empty at the request
//   count_o        registered entry count
//   overflow_o     sticky: a push arrived while wr_ready_o = 0
// -----------------------------------------------------------------------------
module unsat_clause_buffer #(
    parameter int CLAUSE_ADDRESS_WIDTH = 13,
    parameter int DEPTH                = 256,
    parameter int WRITE_PORTS          = 2,
    parameter int RAND_WIDTH           = 16
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        clear_i,
    input  logic [WRITE_PORTS-1:0]                      wr_valid_i,
    input  logic [WRITE_PORTS*CLAUSE_ADDRESS_WIDTH-1:0] wr_clause_i,
    output logic                                        wr_ready_o,
    input  logic                                        pick_req_i,
    input  logic [RAND_WIDTH-1:0]                       rand_i,
    output logic                                        pick_valid_o,
    output logic [CLAUSE_ADDRESS_WIDTH-1:0]             pick_clause_o,
    output logic                                        pick_empty_o,
    output logic [$clog2(DEPTH+1)-1:0]                  count_o,
    output logic                                        overflow_o
);

    localparam int CAW = CLAUSE_ADDRESS_WIDTH;
    // Count width covers 0..DEPTH inclusive.
    localparam int CW  = $clog2(DEPTH + 1);
    // Storage address width.
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Common width for the random/count comparison in the pick path.
    localparam int WW  = (RAND_WIDTH > CW) ? RAND_WIDTH : CW;
    // Highest count at which a full WRITE_PORTS-wide push still fits.
    localparam logic [CW-1:0] READY_LIMIT = CW'(DEPTH - WRITE_PORTS);

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Number of valid lanes strictly below lane n.
    function automatic logic [CW-1:0] popcount_below(
        input logic [WRITE_PORTS-1:0] v,
        input int                     n
    );
        logic [CW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < WRITE_PORTS; i++) begin
            if ((i < n) && v[i]) begin
                cnt = cnt + CW'(1);
            end
        end
        return cnt;
    endfunction

    // Sets every bit below the most significant set bit: the smallest
    // all-ones value that is >= x.
    function automatic logic [CW-1:0] smear(input logic [CW-1:0] x);
        logic [CW-1:0] m;
        m = x;
        for (int i = 1; i < CW; i++) begin
            m = m | (x >> i);
        end
        return m;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [CAW-1:0] mem_q [DEPTH];

    logic [CW-1:0]  count_q,       count_d;
    logic           overflow_q,    overflow_d;

    // Pick stage 1: request accepted, index computed.
    logic           s1_valid_q,    s1_valid_d;
    logic           s1_empty_q,    s1_empty_d;
    logic [AW-1:0]  s1_idx_q,      s1_idx_d;

    // Pick stage 2: storage read result.
    logic           pick_valid_q;
    logic           pick_empty_q;
    logic [CAW-1:0] pick_clause_q;

    // -------------------------------------------------------------------------
    // Push lanes: unpack data and compute compacted write addresses
    // -------------------------------------------------------------------------
    logic [CAW-1:0] lane_data [WRITE_PORTS];
    logic [AW-1:0]  lane_addr [WRITE_PORTS];

    genvar gi;
    generate
        for (gi = 0; gi < WRITE_PORTS; gi++) begin : g_lane
            assign lane_data[gi] = wr_clause_i[gi*CAW +: CAW];
            // Each valid lane lands after all valid lanes below it, so
            // invalid lanes leave no holes.
            assign lane_addr[gi] = AW'(count_q + popcount_below(wr_valid_i, gi));
        end
    endgenerate

    logic [CW-1:0] push_count;
    logic          wr_any;
    logic          wr_ready;
    logic          push_accept;
    logic          push_reject;

    assign push_count  = popcount_below(wr_valid_i, WRITE_PORTS);
    assign wr_any      = |wr_valid_i;
    // Conservative: ready only when a full-width push fits, regardless of
    // how many lanes are actually valid this cycle.
    assign wr_ready    = (count_q <= READY_LIMIT);
    // Clear wins over pushes; pushes during a clear are neither accepted
    // nor counted as overflow.
    assign push_accept = wr_any &  wr_ready & ~clear_i;
    assign push_reject = wr_any & ~wr_ready & ~clear_i;

    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        if (clear_i) begin
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push_accept) begin
                count_d = count_q + push_count;
            end
            if (push_reject) begin
                overflow_d = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Pick index: mask the random value to the smallest 2^n-1 covering c-1,
    // then fold the upper half back once. Since r < 2c the fold always lands
    // inside [0, c), avoiding a modulo divider.
    // -------------------------------------------------------------------------
    logic [CW-1:0] pick_mask;
    logic [WW-1:0] rand_masked;
    logic [WW-1:0] count_ext;

    always_comb begin
        pick_mask   = '0;
        if (count_q != '0) begin
            pick_mask = smear(count_q - CW'(1));
        end
        rand_masked = WW'(rand_i) & WW'(pick_mask);
        count_ext   = WW'(count_q);
        if (rand_masked >= count_ext) begin
            s1_idx_d = AW'(rand_masked - count_ext);
        end else begin
            s1_idx_d = AW'(rand_masked);
        end
        // Pick uses the count before any same-cycle push or clear.
        s1_valid_d = pick_req_i;
        s1_empty_d = pick_req_i & (count_q == '0);
    end

    // -------------------------------------------------------------------------
    // Storage: not reset and not cleared; only accepted pushes write it.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int k = 0; k < WRITE_PORTS; k++) begin
            if (push_accept && wr_valid_i[k]) begin
                mem_q[lane_addr[k]] <= lane_data[k];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Control registers and pick pipeline
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q       <= '0;
            overflow_q    <= 1'b0;
            s1_valid_q    <= 1'b0;
            s1_empty_q    <= 1'b0;
            s1_idx_q      <= '0;
            pick_valid_q  <= 1'b0;
            pick_empty_q  <= 1'b0;
            pick_clause_q <= '0;
        end else begin
            count_q      <= count_d;
            overflow_q   <= overflow_d;

            s1_valid_q   <= s1_valid_d;
            s1_empty_q   <= s1_empty_d;
            s1_idx_q     <= s1_idx_d;

            pick_valid_q <= s1_valid_q;
            pick_empty_q <= s1_valid_q & s1_empty_q;
            // The clause output only moves on a result, so it holds between
            // strobes; an empty pick reports clause 0.
            if (s1_valid_q) begin
                if (s1_empty_q) begin
                    pick_clause_q <= '0;
                end else begin
                    pick_clause_q <= mem_q[s1_idx_q];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign wr_ready_o    = wr_ready;
    assign count_o       = count_q;
    assign overflow_o    = overflow_q;
    assign pick_valid_o  = pick_valid_q;
    assign pick_empty_o  = pick_empty_q;
    assign pick_clause_o = pick_clause_q;

endmodule

// File: tb/tb_unsat_clause_buffer.sv
// -----------------------------------------------------------------------------
// tb_unsat_clause_buffer
//
// Directed self-checking bench for unsat_clause_buffer with the default
// parameters (CAW 13, DEPTH 256, 2 write lanes, 16-bit random input).
// Inputs change 1 time unit after the rising edge and outputs are sampled at
// the same point, so every check sees the state left by the preceding edge.
// -----------------------------------------------------------------------------
module tb_unsat_clause_buffer;

    localparam int CAW   = 13;
    localparam int DEPTH = 256;
    localparam int WP    = 2;
    localparam int RW    = 16;
    localparam int CW    = 9;

    logic                clk = 1'b0;
    logic                reset;
    logic                clear_i;
    logic [WP-1:0]       wr_valid_i;
    logic [WP*CAW-1:0]   wr_clause_i;
    logic                wr_ready_o;
    logic                pick_req_i;
    logic [RW-1:0]       rand_i;
    logic                pick_valid_o;
    logic [CAW-1:0]      pick_clause_o;
    logic                pick_empty_o;
    logic [CW-1:0]       count_o;
    logic                overflow_o;

    int checks = 0;
    int errors = 0;

    unsat_clause_buffer #(
        .CLAUSE_ADDRESS_WIDTH (CAW),
        .DEPTH                (DEPTH),
        .WRITE_PORTS          (WP),
        .RAND_WIDTH           (RW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .clear_i       (clear_i),
        .wr_valid_i    (wr_valid_i),
        .wr_clause_i   (wr_clause_i),
        .wr_ready_o    (wr_ready_o),
        .pick_req_i    (pick_req_i),
        .rand_i        (rand_i),
        .pick_valid_o  (pick_valid_o),
        .pick_clause_o (pick_clause_o),
        .pick_empty_o  (pick_empty_o),
        .count_o       (count_o),
        .overflow_o    (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One push cycle; lane 0 data is a, lane 1 data is b.
    task automatic push2(input logic [1:0] v, input logic [CAW-1:0] a, input logic [CAW-1:0] b);
        wr_valid_i  = v;
        wr_clause_i = {b, a};
        tick();
        wr_valid_i  = '0;
        wr_clause_i = '0;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        clear_i     = 1'b0;
        wr_valid_i  = '0;
        wr_clause_i = '0;
        pick_req_i  = 1'b0;
        rand_i      = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (count_o !== 9'd0) begin
            errors++; $display("FAIL reset_count: got %0d expected 0", count_o);
        end
        checks++;
        if (overflow_o !== 1'b0 || pick_valid_o !== 1'b0 || pick_empty_o !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got ovf=%b valid=%b empty=%b expected 0 0 0",
                               overflow_o, pick_valid_o, pick_empty_o);
        end
        checks++;
        if (pick_clause_o !== 13'd0) begin
            errors++; $display("FAIL reset_clause: got %0h expected 0", pick_clause_o);
        end
        checks++;
        if (wr_ready_o !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b expected 1", wr_ready_o);
        end
        $display("test_reset done");
    endtask

    // Three double-lane pushes, then read back every entry in order.
    task automatic test_push_both();
        logic [CAW-1:0] exp_q [6];
        exp_q = '{13'd5, 13'd9, 13'd5, 13'd9, 13'd5, 13'd9};
        repeat (3) push2(2'b11, 13'd5, 13'd9);
        checks++;
        if (count_o !== 9'd6) begin
            errors++; $display("FAIL push_both_count: got %0d expected 6", count_o);
        end
        // count 6 -> mask 7, rand 0..5 maps straight to the entry index.
        for (int k = 0; k <= 6; k++) begin
            if (k < 6) begin
                pick_req_i = 1'b1;
                rand_i     = RW'(k);
            end else begin
                pick_req_i = 1'b0;
            end
            tick();
            if (k >= 1) begin
                checks++;
                if (pick_valid_o !== 1'b1 || pick_empty_o !== 1'b0 || pick_clause_o !== exp_q[k-1]) begin
                    errors++; $display("FAIL push_both_entry%0d: got v=%b e=%b clause=%0d expected 1 0 %0d",
                                       k-1, pick_valid_o, pick_empty_o, pick_clause_o, exp_q[k-1]);
                end
            end
        end
        tick();
        checks++;
        if (pick_valid_o !== 1'b0) begin
            errors++; $display("FAIL push_both_tail: got valid=%b expected 0", pick_valid_o);
        end
        $display("test_push_both done");
    endtask

    // Only lane 1 valid: it must land in slot 0.
    task automatic test_compaction();
        do_clear();
        push2(2'b10, 13'h0777, 13'h1ABC);
        checks++;
        if (count_o !== 9'd1) begin
            errors++; $display("FAIL compaction_count: got %0d expected 1", count_o);
        end
        pick_req_i = 1'b1;
        rand_i     = 16'hFFFF;   // count 1 -> mask 0 -> index 0
        tick();
        pick_req_i = 1'b0;
        tick();
        checks++;
        if (pick_valid_o !== 1'b1 || pick_clause_o !== 13'h1ABC) begin
            errors++; $display("FAIL compaction_entry0: got v=%b clause=%0h expected 1 1abc",
                               pick_valid_o, pick_clause_o);
        end
        $display("test_compaction done");
    endtask

    // Five entries 10..14: latency check, then back-to-back picks.
    task automatic test_pick();
        logic [RW-1:0]  rnd_q [9];
        logic [CAW-1:0] exp_q [9];
        rnd_q = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'hFFFE};
        exp_q = '{13'd10, 13'd11, 13'd12, 13'd13, 13'd14, 13'd10, 13'd11, 13'd12, 13'd11};
        do_clear();
        push2(2'b11, 13'd10, 13'd11);
        push2(2'b11, 13'd12, 13'd13);
        push2(2'b01, 13'd14, 13'h1FFF);
        checks++;
        if (count_o !== 9'd5) begin
            errors++; $display("FAIL pick_count: got %0d expected 5", count_o);
        end
        pick_req_i = 1'b1;
        rand_i     = 16'd6;      // m 7, r 6 >= 5 -> idx 1
        tick();
        pick_req_i = 1'b0;
        checks++;
        if (pick_valid_o !== 1'b0) begin
            errors++; $display("FAIL pick_latency1: got valid=%b expected 0", pick_valid_o);
        end
        tick();
        checks++;
        if (pick_valid_o !== 1'b1 || pick_empty_o !== 1'b0 || pick_clause_o !== 13'd11) begin
            errors++; $display("FAIL pick_single: got v=%b e=%b clause=%0d expected 1 0 11",
                               pick_valid_o, pick_empty_o, pick_clause_o);
        end
        tick();
        checks++;
        if (pick_valid_o !== 1'b0 || pick_clause_o !== 13'd11) begin
            errors++; $display("FAIL pick_hold: got v=%b clause=%0d expected 0 11",
                               pick_valid_o, pick_clause_o);
        end
        for (int k = 0; k <= 9; k++) begin
            if (k < 9) begin
                pick_req_i = 1'b1;
                rand_i     = rnd_q[k];
            end else begin
                pick_req_i = 1'b0;
            end
            tick();
            if (k >= 1) begin
                checks++;
                if (pick_valid_o !== 1'b1 || pick_clause_o !== exp_q[k-1]) begin
                    errors++; $display("FAIL pick_b2b%0d: got v=%b clause=%0d expected 1 %0d",
                                       k-1, pick_valid_o, pick_clause_o, exp_q[k-1]);
                end
            end
        end
        tick();
        checks++;
        if (pick_valid_o !== 1'b0) begin
            errors++; $display("FAIL pick_b2b_tail: got valid=%b expected 0", pick_valid_o);
        end
        $display("test_pick done");
    endtask

    // Fill to DEPTH-1, overflow with a single lane, then clear with a push.
    task automatic test_full_overflow();
        do_clear();
        for (int j = 0; j < 127; j++) begin
            push2(2'b11, CAW'(100 + 2*j), CAW'(101 + 2*j));
        end
        checks++;
        if (count_o !== 9'd254 || wr_ready_o !== 1'b1) begin
            errors++; $display("FAIL full_254: got count=%0d ready=%b expected 254 1", count_o, wr_ready_o);
        end
        push2(2'b01, 13'd354, 13'd0);
        checks++;
        if (count_o !== 9'd255 || wr_ready_o !== 1'b0 || overflow_o !== 1'b0) begin
            errors++; $display("FAIL full_255: got count=%0d ready=%b ovf=%b expected 255 0 0",
                               count_o, wr_ready_o, overflow_o);
        end
        push2(2'b01, 13'h0ABC, 13'd0);
        checks++;
        if (count_o !== 9'd255 || overflow_o !== 1'b1) begin
            errors++; $display("FAIL overflow: got count=%0d ovf=%b expected 255 1", count_o, overflow_o);
        end
        // count 255 -> mask 255: rand 254 -> idx 254, rand 255 folds to 0.
        pick_req_i = 1'b1;
        rand_i     = 16'd254;
        tick();
        rand_i     = 16'd255;
        tick();
        pick_req_i = 1'b0;
        checks++;
        if (pick_valid_o !== 1'b1 || pick_clause_o !== 13'd354) begin
            errors++; $display("FAIL full_pick254: got v=%b clause=%0d expected 1 354", pick_valid_o, pick_clause_o);
        end
        tick();
        checks++;
        if (pick_valid_o !== 1'b1 || pick_clause_o !== 13'd100) begin
            errors++; $display("FAIL full_pick_fold: got v=%b clause=%0d expected 1 100", pick_valid_o, pick_clause_o);
        end
        clear_i    = 1'b1;
        wr_valid_i = 2'b11;
        tick();
        clear_i    = 1'b0;
        wr_valid_i = '0;
        checks++;
        if (count_o !== 9'd0 || overflow_o !== 1'b0 || wr_ready_o !== 1'b1) begin
            errors++; $display("FAIL clear: got count=%0d ovf=%b ready=%b expected 0 0 1",
                               count_o, overflow_o, wr_ready_o);
        end
        $display("test_full_overflow done");
    endtask

    // Empty pick, then a pick in the same cycle as a clear.
    task automatic test_empty_and_clear_pick();
        pick_req_i = 1'b1;
        rand_i     = 16'd5;
        tick();
        pick_req_i = 1'b0;
        tick();
        checks++;
        if (pick_valid_o !== 1'b1 || pick_empty_o !== 1'b1 || pick_clause_o !== 13'd0) begin
            errors++; $display("FAIL empty_pick: got v=%b e=%b clause=%0d expected 1 1 0",
                               pick_valid_o, pick_empty_o, pick_clause_o);
        end
        tick();
        checks++;
        if (pick_valid_o !== 1'b0 || pick_empty_o !== 1'b0) begin
            errors++; $display("FAIL empty_pick_tail: got v=%b e=%b expected 0 0", pick_valid_o, pick_empty_o);
        end
        push2(2'b11, 13'd20, 13'd21);
        push2(2'b01, 13'd22, 13'd0);
        checks++;
        if (count_o !== 9'd3) begin
            errors++; $display("FAIL clear_pick_count: got %0d expected 3", count_o);
        end
        clear_i    = 1'b1;
        pick_req_i = 1'b1;
        rand_i     = 16'd2;
        tick();
        clear_i    = 1'b0;
        pick_req_i = 1'b0;
        checks++;
        if (count_o !== 9'd0) begin
            errors++; $display("FAIL clear_pick_cleared: got %0d expected 0", count_o);
        end
        tick();
        checks++;
        if (pick_valid_o !== 1'b1 || pick_empty_o !== 1'b0 || pick_clause_o !== 13'd22) begin
            errors++; $display("FAIL clear_pick_result: got v=%b e=%b clause=%0d expected 1 0 22",
                               pick_valid_o, pick_empty_o, pick_clause_o);
        end
        $display("test_empty_and_clear_pick done");
    endtask

    // Reset in the cycle after a pick request drops the in-flight pick.
    task automatic test_reset_midflight();
        push2(2'b11, 13'd30, 13'd31);
        checks++;
        if (count_o !== 9'd2) begin
            errors++; $display("FAIL midflight_count: got %0d expected 2", count_o);
        end
        pick_req_i = 1'b1;
        rand_i     = 16'd1;
        tick();
        pick_req_i = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (count_o !== 9'd0 || pick_valid_o !== 1'b0) begin
            errors++; $display("FAIL midflight_async: got count=%0d v=%b expected 0 0", count_o, pick_valid_o);
        end
        tick();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (pick_valid_o !== 1'b0) begin
                errors++; $display("FAIL midflight_no_pulse%0d: got v=%b expected 0", k, pick_valid_o);
            end
        end
        checks++;
        if (wr_ready_o !== 1'b1 || count_o !== 9'd0) begin
            errors++; $display("FAIL midflight_after: got ready=%b count=%0d expected 1 0", wr_ready_o, count_o);
        end
        $display("test_reset_midflight done");
    endtask

    initial begin
        test_reset();
        test_push_both();
        test_compaction();
        test_pick();
        test_full_overflow();
        test_empty_and_clear_pick();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1);
    end

endmodule
